// File: rtl/mips_cpu_alu_ctrl.sv
// Issue controller between decode and mips_cpu_ALU: maps funct/opcode to the ALU op,
// waits one cycle for the falling-edge ALU result, flags signed overflow and returns it.
module mips_cpu_alu_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_sa,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic [4:0]  out_dest,
  output logic        out_we,
  output logic        out_ovf,
  output logic        out_illegal
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_DONE = 2'd2} state_t;

  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_ADD  = 2'd1;
  localparam logic [1:0] KIND_SUB  = 2'd2;

  state_t      r_state;
  logic [4:0]  r_dest;
  logic [1:0]  r_kind;

  logic        w_legal;
  logic [4:0]  w_op;
  logic [31:0] w_b;
  logic [4:0]  w_sa;
  logic [4:0]  w_dest;
  logic [1:0]  w_kind;
  logic [31:0] w_imm_se;
  logic [31:0] w_imm_ze;
  logic        w_accept;
  logic        w_ovf;
  logic        w_unused_rs;

  assign w_imm_se    = {{16{instr[15]}}, instr[15:0]};
  assign w_imm_ze    = {16'h0000, instr[15:0]};
  // The rs field is already resolved into rs_val by the register file.
  assign w_unused_rs = ^instr[25:21];
  assign in_ready    = reset_n && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
  assign w_accept    = in_valid && in_ready;

  // Decode the incoming instruction into ALU op, b operand, shift amount and destination.
  always_comb begin
    w_legal = 1'b1;
    w_op    = 5'd0;
    w_b     = 32'd0;
    w_sa    = 5'd0;
    w_dest  = 5'd0;
    w_kind  = KIND_NONE;
    if (instr[31:26] == 6'h00) begin
      w_b    = rt_val;
      w_sa   = instr[10:6];
      w_dest = instr[15:11];
      case (instr[5:0])
        6'h00:   w_op = 5'd6;
        6'h02:   w_op = 5'd7;
        6'h03:   w_op = 5'd8;
        6'h04:   w_op = 5'd9;
        6'h06:   w_op = 5'd10;
        6'h07:   w_op = 5'd11;
        6'h20:   begin w_op = 5'd2; w_kind = KIND_ADD; end
        6'h21:   w_op = 5'd2;
        6'h22:   begin w_op = 5'd3; w_kind = KIND_SUB; end
        6'h23:   w_op = 5'd3;
        6'h24:   w_op = 5'd0;
        6'h25:   w_op = 5'd1;
        6'h26:   w_op = 5'd5;
        6'h2A:   w_op = 5'd4;
        6'h2B:   w_op = 5'd13;
        default: w_legal = 1'b0;
      endcase
    end else begin
      w_dest = instr[20:16];
      case (instr[31:26])
        6'h08:   begin w_op = 5'd2;  w_b = w_imm_se; w_kind = KIND_ADD; end
        6'h09:   begin w_op = 5'd2;  w_b = w_imm_se; end
        6'h0A:   begin w_op = 5'd4;  w_b = w_imm_se; end
        6'h0B:   begin w_op = 5'd13; w_b = w_imm_se; end
        6'h0C:   begin w_op = 5'd0;  w_b = w_imm_ze; end
        6'h0D:   begin w_op = 5'd1;  w_b = w_imm_ze; end
        6'h0E:   begin w_op = 5'd5;  w_b = w_imm_ze; end
        6'h0F:   begin w_op = 5'd12; w_b = w_imm_ze; end
        default: w_legal = 1'b0;
      endcase
    end
  end

  // Signed overflow of the issued add/sub, judged from the held operands and the ALU result.
  always_comb begin
    w_ovf = 1'b0;
    case (r_kind)
      KIND_ADD: w_ovf = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      KIND_SUB: w_ovf = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      default:  w_ovf = 1'b0;
    endcase
  end

  // Issue FSM; ALU inputs only move on an accepting edge so the negedge sample is stable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_dest      <= 5'd0;
      r_kind      <= KIND_NONE;
      alu_op      <= 5'd0;
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
      alu_sa      <= 5'd0;
      out_valid   <= 1'b0;
      out_result  <= 32'd0;
      out_zero    <= 1'b0;
      out_dest    <= 5'd0;
      out_we      <= 1'b0;
      out_ovf     <= 1'b0;
      out_illegal <= 1'b0;
    end else if (w_accept) begin
      if (w_legal) begin
        alu_op    <= w_op;
        alu_a     <= rs_val;
        alu_b     <= w_b;
        alu_sa    <= w_sa;
        r_dest    <= w_dest;
        r_kind    <= w_kind;
        out_valid <= 1'b0;
        r_state   <= ST_EXEC;
      end else begin
        out_valid   <= 1'b1;
        out_result  <= 32'd0;
        out_zero    <= 1'b0;
        out_dest    <= 5'd0;
        out_we      <= 1'b0;
        out_ovf     <= 1'b0;
        out_illegal <= 1'b1;
        r_state     <= ST_DONE;
      end
    end else begin
      case (r_state)
        ST_EXEC: begin
          out_result  <= alu_result;
          out_zero    <= alu_zero;
          out_dest    <= r_dest;
          out_ovf     <= w_ovf;
          out_we      <= !w_ovf && (r_dest != 5'd0);
          out_illegal <= 1'b0;
          out_valid   <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_state   <= ST_DONE;
          end
        end
        ST_IDLE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_alu_ctrl.sv
// Scoreboard bench for mips_cpu_alu_ctrl: a negedge-registered ALU model drives alu_result,
// expectations come from MIPS instruction semantics and are popped on each output handshake.
module tb_mips_cpu_alu_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [4:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_sa;
  logic [31:0] alu_result = 32'd0;
  logic        alu_zero = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_dest;
  logic        out_we;
  logic        out_ovf;
  logic        out_illegal;

  mips_cpu_alu_ctrl dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_sa(alu_sa),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_dest(out_dest), .out_we(out_we),
    .out_ovf(out_ovf), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        illegal;
    logic [31:0] result;
    logic        zero;
    logic [4:0]  dest;
    logic        we;
    logic        ovf;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sa;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          ready_mode = 1;
  logic [4:0]  last_op = 5'd0;
  logic [31:0] last_a = 32'd0;
  logic [31:0] last_b = 32'd0;
  logic [4:0]  last_sa = 5'd0;
  logic [5:0]  rfun [15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                             6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B};

  always @(posedge clk) cyc <= cyc + 1;

  // Environment: behavioural mips_cpu_ALU registering its result on the falling edge.
  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sa);
    case (op)
      5'd0:  return a & b;
      5'd1:  return a | b;
      5'd2:  return a + b;
      5'd3:  return a - b;
      5'd4:  return {31'd0, ($signed(a) < $signed(b))};
      5'd5:  return a ^ b;
      5'd6:  return b << sa;
      5'd7:  return b >> sa;
      5'd8:  return $signed(b) >>> sa;
      5'd9:  return b << a[4:0];
      5'd10: return b >> a[4:0];
      5'd11: return $signed(b) >>> a[4:0];
      5'd12: return {b[15:0], 16'h0000};
      5'd13: return {31'd0, (a < b)};
      5'd14: return a;
      5'd15: return b;
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    alu_result <= alu_f(alu_op, alu_a, alu_b, alu_sa);
    alu_zero   <= (alu_f(alu_op, alu_a, alu_b, alu_sa) == 32'd0);
  end

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sa,
                                       input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Reference: what the MIPS instruction means, plus the ALU code it must be issued with.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rsv,
                                 input logic [31:0] rtv);
    exp_t        e;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] se;
    logic [31:0] ze;
    longint      s;
    int          ck;
    opc = ins[31:26];
    fn  = ins[5:0];
    sh  = ins[10:6];
    se  = {{16{ins[15]}}, ins[15:0]};
    ze  = {16'h0000, ins[15:0]};
    e   = '{default: '0};
    e.a = rsv;
    ck  = 0;
    if (opc == 6'h00) begin
      e.b = rtv; e.sa = sh; e.dest = ins[15:11];
      case (fn)
        6'h00: begin e.op = 5'd6;  e.result = rtv << sh; end
        6'h02: begin e.op = 5'd7;  e.result = rtv >> sh; end
        6'h03: begin e.op = 5'd8;  e.result = $signed(rtv) >>> sh; end
        6'h04: begin e.op = 5'd9;  e.result = rtv << rsv[4:0]; end
        6'h06: begin e.op = 5'd10; e.result = rtv >> rsv[4:0]; end
        6'h07: begin e.op = 5'd11; e.result = $signed(rtv) >>> rsv[4:0]; end
        6'h20: begin e.op = 5'd2;  e.result = rsv + rtv; ck = 1; end
        6'h21: begin e.op = 5'd2;  e.result = rsv + rtv; end
        6'h22: begin e.op = 5'd3;  e.result = rsv - rtv; ck = 2; end
        6'h23: begin e.op = 5'd3;  e.result = rsv - rtv; end
        6'h24: begin e.op = 5'd0;  e.result = rsv & rtv; end
        6'h25: begin e.op = 5'd1;  e.result = rsv | rtv; end
        6'h26: begin e.op = 5'd5;  e.result = rsv ^ rtv; end
        6'h2A: begin e.op = 5'd4;  e.result = ($signed(rsv) < $signed(rtv)) ? 32'd1 : 32'd0; end
        6'h2B: begin e.op = 5'd13; e.result = (rsv < rtv) ? 32'd1 : 32'd0; end
        default: e.illegal = 1'b1;
      endcase
    end else begin
      e.dest = ins[20:16];
      case (opc)
        6'h08: begin e.op = 5'd2;  e.b = se; e.result = rsv + se; ck = 1; end
        6'h09: begin e.op = 5'd2;  e.b = se; e.result = rsv + se; end
        6'h0A: begin e.op = 5'd4;  e.b = se; e.result = ($signed(rsv) < $signed(se)) ? 32'd1 : 32'd0; end
        6'h0B: begin e.op = 5'd13; e.b = se; e.result = (rsv < se) ? 32'd1 : 32'd0; end
        6'h0C: begin e.op = 5'd0;  e.b = ze; e.result = rsv & ze; end
        6'h0D: begin e.op = 5'd1;  e.b = ze; e.result = rsv | ze; end
        6'h0E: begin e.op = 5'd5;  e.b = ze; e.result = rsv ^ ze; end
        6'h0F: begin e.op = 5'd12; e.b = ze; e.result = ze << 16; end
        default: e.illegal = 1'b1;
      endcase
    end
    if (ck == 1) s = longint'($signed(e.a)) + longint'($signed(e.b));
    else         s = longint'($signed(e.a)) - longint'($signed(e.b));
    e.ovf = (ck != 0) && ((s > 64'sd2147483647) || (s < -64'sd2147483648));
    if (e.illegal) begin
      e.result = 32'd0; e.ovf = 1'b0; e.we = 1'b0;
      e.op = last_op; e.a = last_a; e.b = last_b; e.sa = last_sa;
    end else begin
      e.zero = (e.result == 32'd0);
      e.we   = !e.ovf && (e.dest != 5'd0);
    end
    return e;
  endfunction

  task automatic issue(input logic [31:0] ins, input logic [31:0] rsv, input logic [31:0] rtv);
    exp_t e;
    bit   done = 1'b0;
    instr = ins; rs_val = rsv; rt_val = rtv; in_valid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        e     = model(ins, rsv, rtv);
        e.cyc = cyc + (e.illegal ? 1 : 2);
        sb_q.push_back(e);
        if (!e.illegal) begin
          last_op = e.op; last_a = e.a; last_b = e.b; last_sa = e.sa;
        end
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected accept of %h", ins);
    end
  endtask

  // Monitor: compare each completed output handshake against the oldest expectation.
  bit   seen = 1'b0;
  int   seen_cyc = 0;
  exp_t me;
  always @(negedge clk) begin
    if (!reset_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin seen = 1'b1; seen_cyc = cyc; end
      if (out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_output: got result %h expected no output", out_result);
        end else begin
          me = sb_q.pop_front();
          chk("illegal", {31'd0, out_illegal}, {31'd0, me.illegal});
          chk("result", out_result, me.result);
          chk("we", {31'd0, out_we}, {31'd0, me.we});
          chk("ovf", {31'd0, out_ovf}, {31'd0, me.ovf});
          if (!me.illegal) begin
            chk("dest", {27'd0, out_dest}, {27'd0, me.dest});
            chk("zero", {31'd0, out_zero}, {31'd0, me.zero});
          end
          chk("alu_op", {27'd0, alu_op}, {27'd0, me.op});
          chk("alu_a", alu_a, me.a);
          chk("alu_b", alu_b, me.b);
          chk("alu_sa", {27'd0, alu_sa}, {27'd0, me.sa});
          chk("latency", seen_cyc, me.cyc);
        end
        seen = 1'b0;
      end
    end
  end

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 4))
      0:       return 32'h7FFFFFFF;
      1:       return 32'h80000000;
      2:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ins;
    int          sel;
    bit          got;
    reset_n = 1'b0; in_valid = 1'b0; instr = 32'd0; rs_val = 32'd0; rt_val = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_alu_op", {27'd0, alu_op}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    issue(mk_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'h7FFFFFFF, 32'd1);
    issue(mk_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'h7FFFFFFF, 32'd1);
    issue(mk_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h22), 32'h80000000, 32'd1);
    issue(mk_i(6'h0D, 5'd0, 5'd5, 16'h8001), 32'd0, 32'd0);
    issue(mk_i(6'h0A, 5'd1, 5'd6, 16'hFFFF), 32'hFFFFFFF0, 32'd0);
    issue(mk_i(6'h0F, 5'd0, 5'd7, 16'h1234), 32'd0, 32'd0);
    issue(mk_r(5'd1, 5'd2, 5'd8, 5'd0, 6'h07), 32'd4, 32'h80000000);
    issue(mk_r(5'd0, 5'd2, 5'd0, 5'd31, 6'h00), 32'd0, 32'd1);
    repeat (3) begin @(posedge clk); #1; end

    // Reset while the ALU is being fed: operation abandoned.
    issue(mk_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'h12345678, 32'h11111111);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_exec_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_exec_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_exec_alu_op", {27'd0, alu_op}, 32'd0);
    @(posedge clk); #1;
    sb_q.delete();
    last_op = 5'd0; last_a = 32'd0; last_b = 32'd0; last_sa = 5'd0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Back-pressure with an illegal instruction waiting behind the held result.
    ready_mode = 0;
    @(posedge clk); #1;
    issue(mk_r(5'd1, 5'd2, 5'd9, 5'd0, 6'h26), 32'hF0F0F0F0, 32'h0FF00FF0);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL bp_wait: got out_valid=0 expected 1");
    end
    instr = {6'h3F, 26'd0}; rs_val = 32'hDEADBEEF; rt_val = 32'hCAFEF00D; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_result", out_result, sb_q[0].result);
    end
    @(posedge clk); #1;
    ready_mode = 1;
    issue({6'h3F, 26'd0}, 32'hDEADBEEF, 32'hCAFEF00D);
    issue(mk_r(5'd3, 5'd4, 5'd5, 5'd0, 6'h01), 32'd1, 32'd2);

    // Randomized traffic with random consumer stalls.
    ready_mode = 2;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5) begin
        ins = mk_r(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   rfun[$urandom_range(0, 14)]);
      end else if (sel < 9) begin
        ins = mk_i(6'h08 + 6'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 16'($urandom));
      end else if ($urandom_range(0, 1) == 0) begin
        ins = {6'h23, 26'($urandom)};
      end else begin
        ins = mk_r(5'($urandom), 5'($urandom), 5'($urandom), 5'd0, 6'h08);
      end
      issue(ins, pick_val(), pick_val());
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    ready_mode = 1;
    for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(negedge clk);
    chk("drain_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
